// File: rtl/pixel_frame_buffer_pkg.sv
// Shared types and constants for the ping-pong pixel frame buffer.
// PIXEL_FRAME_CHECKSUM_EN adds the R_SUM reader state for the checksum word.
package pixel_frame_buffer_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int PAIR_W     = 2 * DATA_W_DEF;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_DONE
    } wr_state_t;

`ifdef PIXEL_FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_STREAM,
        R_SUM
    } rd_state_t;
`else
    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_STREAM
    } rd_state_t;
`endif

endpackage

// File: rtl/pixel_frame_buffer_bank_ram.sv
// Two-bank simple dual-port sample RAM, address = {bank, index}.
// Registered read; contents are not reset.
module pfb_bank_ram
    import pixel_frame_buffer_pkg::*;
#(
    parameter  int N_PIXELS = 128,
    parameter  int WIDTH    = PAIR_W,
    localparam int AW       = $clog2(N_PIXELS) + 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2*N_PIXELS];

    // Writer port plus one-cycle-latency read port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pixel_frame_buffer.sv
// Ping-pong frame assembler: fills one bank while streaming the other.
// Define PIXEL_FRAME_CHECKSUM_EN to append a per-frame checksum word.
module pixel_frame_buffer
    import pixel_frame_buffer_pkg::*;
#(
    parameter  int N_PIXELS = 128,
    parameter  int DATA_W   = DATA_W_DEF,
    localparam int IW       = $clog2(N_PIXELS),
    localparam int PW       = 2 * DATA_W
) (
    input  logic              clk_4M,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [DATA_W-1:0] pdata0,
    input  logic [DATA_W-1:0] pdata1,
    input  logic              new_data,
    output logic [PW-1:0]     out_data,
    output logic [IW-1:0]     out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              frame_drop,
    output logic              busy
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N_PIXELS - 1);

    wr_state_t   wr_state, wr_next;
    rd_state_t   rd_state, rd_next;
    logic        bank_sel;
    logic [IW-1:0] wr_idx, rd_idx, rd_idx_inc;
    logic        we, wr_last, swap, fire;
    logic [IW:0] waddr, raddr;
    logic [PW-1:0] rdata;

`ifdef PIXEL_FRAME_CHECKSUM_EN
    logic [DATA_W-1:0] sum0, sum1, csum0, csum1;
`endif

    // Writer handshake decode; a sample in the swap cycle is dropped
    always_comb begin
        we = 1'b0;
        if (new_data) begin
            if (frame_start) we = (wr_state != W_DONE);
            else             we = (wr_state == W_FILL);
        end
        wr_last    = we && !frame_start && (wr_idx == LAST_IDX);
        swap       = (wr_state == W_DONE) && (rd_state == R_IDLE);
        frame_drop = (wr_state == W_DONE) && (rd_state != R_IDLE);
        fire       = out_valid && out_ready;
        rd_idx_inc = rd_idx + IW'(1);
        waddr      = {bank_sel, frame_start ? '0 : wr_idx};
        raddr      = {~bank_sel, fire && (rd_state == R_STREAM) ? rd_idx_inc : rd_idx};
    end

    // Writer state register
    always_ff @(posedge clk_4M) begin
        if (reset) wr_state <= W_IDLE;
        else       wr_state <= wr_next;
    end

    // Writer next-state
    always_comb begin
        wr_next = wr_state;
        unique case (wr_state)
            W_IDLE:  if (frame_start) wr_next = W_FILL;
            W_FILL:  if (wr_last) wr_next = W_DONE;
            W_DONE:  wr_next = frame_start ? W_FILL : W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    // Write index and bank select; frame_start restarts the fill
    always_ff @(posedge clk_4M) begin
        if (reset) begin
            wr_idx   <= '0;
            bank_sel <= 1'b0;
        end else begin
            if (frame_start) wr_idx <= we ? IW'(1) : '0;
            else if (we)     wr_idx <= wr_idx + IW'(1);
            if (swap) bank_sel <= ~bank_sel;
        end
    end

`ifdef PIXEL_FRAME_CHECKSUM_EN
    // Running channel sums, snapshotted for the reader at swap
    always_ff @(posedge clk_4M) begin
        if (reset) begin
            sum0  <= '0;
            sum1  <= '0;
            csum0 <= '0;
            csum1 <= '0;
        end else begin
            if (frame_start) begin
                sum0 <= we ? pdata0 : '0;
                sum1 <= we ? pdata1 : '0;
            end else if (we) begin
                sum0 <= sum0 + pdata0;
                sum1 <= sum1 + pdata1;
            end
            if (swap) begin
                csum0 <= sum0;
                csum1 <= sum1;
            end
        end
    end
`endif

    // Reader state register and read index
    always_ff @(posedge clk_4M) begin
        if (reset) begin
            rd_state <= R_IDLE;
            rd_idx   <= '0;
        end else begin
            rd_state <= rd_next;
            if (swap)                                rd_idx <= '0;
            else if (fire && rd_state == R_STREAM)   rd_idx <= rd_idx_inc;
        end
    end

    // Reader next-state
    always_comb begin
        rd_next = rd_state;
        unique case (rd_state)
            R_IDLE:   if (swap) rd_next = R_FETCH;
            R_FETCH:  rd_next = R_STREAM;
`ifdef PIXEL_FRAME_CHECKSUM_EN
            R_STREAM: if (fire && rd_idx == LAST_IDX) rd_next = R_SUM;
            R_SUM:    if (fire) rd_next = R_IDLE;
`else
            R_STREAM: if (fire && rd_idx == LAST_IDX) rd_next = R_IDLE;
`endif
            default:  rd_next = R_IDLE;
        endcase
    end

    // Reader outputs; RAM re-reads the same word while stalled
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_index = '0;
        out_data  = '0;
        busy      = (rd_state != R_IDLE) || swap;
        unique case (rd_state)
            R_STREAM: begin
                out_valid = 1'b1;
                out_index = rd_idx;
                out_data  = rdata;
`ifndef PIXEL_FRAME_CHECKSUM_EN
                out_last  = (rd_idx == LAST_IDX);
`endif
            end
`ifdef PIXEL_FRAME_CHECKSUM_EN
            R_SUM: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = {csum1, csum0};
            end
`endif
            default: ;
        endcase
    end

    pfb_bank_ram #(
        .N_PIXELS (N_PIXELS),
        .WIDTH    (PW)
    ) u_ram (
        .clk   (clk_4M),
        .we    (we),
        .waddr (waddr),
        .wdata ({pdata1, pdata0}),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Scoreboard bench for pixel_frame_buffer (128 pixels, 12-bit samples).
// Expected words are queued at stimulus time and popped by the monitor.
`timescale 1ns/1ps
module tb_pixel_frame_buffer;

    localparam int N  = 128;
    localparam int IW = $clog2(N);
`ifdef PIXEL_FRAME_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef struct packed {
        logic          last;
        logic [IW-1:0] idx;
        logic [23:0]   d;
    } exp_t;

    logic          clk_4M = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic [11:0]   pdata0 = '0;
    logic [11:0]   pdata1 = '0;
    logic          new_data = 1'b0;
    logic [23:0]   out_data;
    logic [IW-1:0] out_index;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          frame_drop;
    logic          busy;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   accepted = 0;
    int   drop_cnt = 0;
    int   rise_cyc = 0;
    int   lat_cyc = 0;
    bit   rand_mode = 1'b0;
    bit   ready_fixed = 1'b1;

    logic          prev_stall = 1'b0;
    logic          prev_valid = 1'b0;
    logic [23:0]   prev_data;
    logic [IW-1:0] prev_idx;
    logic          prev_last;

    pixel_frame_buffer #(.N_PIXELS(N), .DATA_W(12)) dut (
        .clk_4M      (clk_4M),
        .reset       (reset),
        .frame_start (frame_start),
        .pdata0      (pdata0),
        .pdata1      (pdata1),
        .new_data    (new_data),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .frame_drop  (frame_drop),
        .busy        (busy)
    );

    always #5 clk_4M = ~clk_4M;

    always @(posedge clk_4M) cyc++;

    always @(posedge clk_4M) begin
        #1;
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: scoreboard pops, hold-while-stalled, drop and first-valid tracking
    always @(negedge clk_4M) begin
        exp_t e;
        if (prev_stall)
            check("hold", {out_valid, out_last, out_index, out_data},
                  {1'b1, prev_last, prev_idx, prev_data});
        if (out_valid && out_ready) begin
            accepted++;
            if (exp_q.size() == 0) begin
                check("unexpected_word", {out_last, out_index, out_data}, 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("word", {out_last, out_index, out_data}, e);
            end
        end
        if (frame_drop) drop_cnt++;
        if (out_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = out_valid;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_idx   = out_index;
        prev_last  = out_last;
    end

    task automatic pulse_start();
        @(posedge clk_4M); #1;
        frame_start = 1'b1;
        @(posedge clk_4M); #1;
        frame_start = 1'b0;
    endtask

    task automatic send_frame(input int n, input int b0, input int s0,
                              input int b1, input int s1, input bit fs_first,
                              input bit push, input bit chk_busy);
        logic [11:0] v0, v1, a0, a1;
        exp_t e;
        a0 = '0;
        a1 = '0;
        for (int i = 0; i < n; i++) begin
            v0 = 12'(b0 + s0 * i);
            v1 = 12'(b1 + s1 * i);
            a0 = a0 + v0;
            a1 = a1 + v1;
            @(posedge clk_4M); #1;
            new_data    = 1'b1;
            frame_start = fs_first && (i == 0);
            pdata0      = v0;
            pdata1      = v1;
            if (i == n - 1) lat_cyc = cyc;
            if (push) begin
                e.last = (i == N - 1) && !CSUM;
                e.idx  = IW'(i);
                e.d    = {v1, v0};
                exp_q.push_back(e);
            end
            @(posedge clk_4M); #1;
            new_data    = 1'b0;
            frame_start = 1'b0;
            if (chk_busy && i == n - 1) check("busy_at_swap", busy, 1);
            @(posedge clk_4M);
        end
        if (push && CSUM) begin
            e.last = 1'b1;
            e.idx  = '0;
            e.d    = {a1, a0};
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            @(negedge clk_4M);
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        check("drain_done", done, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk_4M);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"},  out_data,  0);
        check({tag, "_index"}, out_index, 0);
        check({tag, "_last"},  out_last,  0);
        check({tag, "_busy"},  busy,      0);
        check({tag, "_drop"},  frame_drop, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc0;
        bit hit;

        repeat (3) @(posedge clk_4M);
        check_idle_outputs("reset");
        @(posedge clk_4M); #1;
        reset = 1'b0;

        // Ramp frame, ready held high
        pulse_start();
        send_frame(N, 0, 1, 4095, -1, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk_4M);
        check("latency", rise_cyc - lat_cyc, 3);
        wait_drain(1000);
        check("no_drop_1", drop_cnt, 0);

        // Random back-pressure
        rand_mode = 1'b1;
        pulse_start();
        send_frame(N, 0, 7, 4000, -3, 1'b0, 1'b1, 1'b0);
        wait_drain(3000);
        rand_mode = 1'b0;
        ready_fixed = 1'b1;

        // Second frame completes while reader is stalled
        ready_fixed = 1'b0;
        pulse_start();
        send_frame(N, 200, 1, 300, 1, 1'b0, 1'b1, 1'b0);
        pulse_start();
        send_frame(N, 7, 3, 9, 5, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk_4M);
        check("drop_once", drop_cnt, 1);
        ready_fixed = 1'b1;
        wait_drain(1000);

        // Aborted partial frame, restart coincident with first sample
        pulse_start();
        send_frame(50, 500, 1, 600, 1, 1'b0, 1'b0, 1'b0);
        send_frame(N, 1000, 1, 3095, -1, 1'b1, 1'b1, 1'b0);
        wait_drain(1000);
        check("no_drop_abort", drop_cnt, 1);

        // Reset in the middle of a stream
        pulse_start();
        send_frame(N, 50, 2, 60, 1, 1'b0, 1'b1, 1'b0);
        acc0 = accepted;
        hit = 1'b0;
        for (int k = 0; k < 500 && !hit; k++) begin
            @(negedge clk_4M);
            if (accepted >= acc0 + 60) hit = 1'b1;
        end
        check("reach_word60", hit, 1);
        @(posedge clk_4M); #1;
        reset = 1'b1;
        @(posedge clk_4M); #1;
        reset = 1'b0;
        exp_q.delete();
        check_idle_outputs("midreset");
        pulse_start();
        send_frame(N, 3, 1, 4090, -2, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk_4M);
        check("latency_after_reset", rise_cyc - lat_cyc, 3);
        wait_drain(1000);

        // Constant frame: checksum word when enabled
        pulse_start();
        send_frame(N, 1, 0, 2, 0, 1'b0, 1'b1, 1'b0);
        wait_drain(1000);
        check("final_drop_count", drop_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
